// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply and radix-2 restoring divide.
// Define HILO_MULDIV_FLUSH_EN to add a flush input that cancels an in-flight operation.
module hilo_muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        md_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wd,
`ifdef HILO_MULDIV_FLUSH_EN
  input  logic              flush,
`endif
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                busy_q, busy_d;

  logic                flush_w;
  logic [2*DATA_W-1:0] prod_w;
  logic [DATA_W:0]     shift_w;
  logic [DATA_W:0]     diff_w;
  logic [DATA_W-1:0]   step_rem_w;
  logic [DATA_W-1:0]   step_quo_w;
  logic [DATA_W-1:0]   q_fix_w;
  logic [DATA_W-1:0]   r_fix_w;
  logic [DATA_W-1:0]   abs_a_w;
  logic [DATA_W-1:0]   abs_b_w;

`ifdef HILO_MULDIV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Datapath: product, one restoring division step, and final sign correction
  always_comb begin
    prod_w = '0;
    if (op_q[0]) begin
      prod_w = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
    end else begin
      prod_w = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    end

    shift_w    = {rem_q, quo_q[DATA_W-1]};
    diff_w     = shift_w - {1'b0, dvs_q};
    step_rem_w = diff_w[DATA_W] ? shift_w[DATA_W-1:0] : diff_w[DATA_W-1:0];
    step_quo_w = {quo_q[DATA_W-2:0], ~diff_w[DATA_W]};

    q_fix_w = (op_q[0] && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? -step_quo_w : step_quo_w;
    r_fix_w = (op_q[0] && a_q[DATA_W-1]) ? -step_rem_w : step_rem_w;

    abs_a_w = (md_op[0] && a[DATA_W-1]) ? -a : a;
    abs_b_w = (md_op[0] && b[DATA_W-1]) ? -b : b;
  end

  // Control: operation launch, step sequencing, result write-back and mthi/mtlo
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_w) begin
          busy_d = 1'b0;
        end else if (start) begin
          a_d    = a;
          b_d    = b;
          op_d   = md_op;
          busy_d = 1'b1;
          if (md_op[1]) begin
            state_d = ST_DIV;
            cnt_d   = 6'(DATA_W);
            rem_d   = '0;
            quo_d   = abs_a_w;
            dvs_d   = abs_b_w;
          end else begin
            state_d = ST_MUL;
            cnt_d   = 6'(MUL_CYCLES);
          end
        end else begin
          if (mthi) hi_d = wd;
          if (mtlo) lo_d = wd;
        end
      end

      ST_MUL: begin
        cnt_d = cnt_q - 6'd1;
        if (flush_w) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == 6'd1) begin
          hi_d    = prod_w[2*DATA_W-1:DATA_W];
          lo_d    = prod_w[DATA_W-1:0];
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_DIV: begin
        cnt_d = cnt_q - 6'd1;
        if (flush_w) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d = step_rem_w;
          quo_d = step_quo_w;
          if (cnt_q == 6'd1) begin
            // A zero divisor leaves HI/LO untouched rather than writing garbage
            if (b_q != '0) begin
              hi_d = r_fix_w;
              lo_d = q_fix_w;
            end
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit; define HILO_MULDIV_FLUSH_EN to also exercise flush.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
`ifdef HILO_MULDIV_FLUSH_EN
  logic        flush;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int numChecks = 0;
  int numFail   = 0;
  int cycles;

  hilo_muldiv_unit #(.MUL_CYCLES(5), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wd    (wd),
`ifdef HILO_MULDIV_FLUSH_EN
    .flush (flush),
`endif
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An operation code must be known whenever a start is presented
  always @(posedge clk) begin
    if (start === 1'b1) begin
      assert (!$isunknown(md_op)) else begin
        numFail++;
        $error("[TB] FAIL md_op_known: observed %b required known value", md_op);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents a one-cycle start from a negedge; returns at the negedge after the launch edge
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] opa, input logic [31:0] opb);
    start = 1'b1;
    md_op = op;
    a     = opa;
    b     = opb;
    @(negedge clk);
    start = 1'b0;
    md_op = 2'b00;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    md_op = 2'b00;
    a     = '0;
    b     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wd    = '0;
`ifdef HILO_MULDIV_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // mult -2 * 3
    applyStimulus(2'b01, 32'hFFFF_FFFE, 32'h3);
    waitIdle(cycles);
    checkOutput("mult_cycles", 32'(cycles), 32'd5);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3
    applyStimulus(2'b00, 32'hFFFF_FFFE, 32'h3);
    waitIdle(cycles);
    checkOutput("multu_cycles", 32'(cycles), 32'd5);
    checkOutput("multu_hi", hi, 32'h0000_0002);
    checkOutput("multu_lo", lo, 32'hFFFF_FFFA);

    // multu all-ones squared, mult -1 * -1
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle(cycles);
    checkOutput("multu_max_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_max_lo", lo, 32'h0000_0001);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle(cycles);
    checkOutput("mult_m1_hi", hi, 32'h0);
    checkOutput("mult_m1_lo", lo, 32'h1);

    // div -7 / 2
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h2);
    waitIdle(cycles);
    checkOutput("div_cycles", 32'(cycles), 32'd32);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    // div 7 / -2
    applyStimulus(2'b11, 32'h7, 32'hFFFF_FFFE);
    waitIdle(cycles);
    checkOutput("div_negb_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_negb_hi", hi, 32'h0000_0001);

    // mtlo in IDLE, then mthi/mtlo separately
    mtlo = 1'b1;
    wd   = 32'h5;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mtlo_idle", lo, 32'h5);
    mthi = 1'b1;
    wd   = 32'h11;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b1;
    wd   = 32'h22;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mthi_idle", hi, 32'h11);
    checkOutput("mtlo_idle2", lo, 32'h22);

    // divu by zero leaves HI/LO untouched
    applyStimulus(2'b10, 32'd100, 32'd0);
    waitIdle(cycles);
    checkOutput("div0_cycles", 32'(cycles), 32'd32);
    checkOutput("div0_hi", hi, 32'h11);
    checkOutput("div0_lo", lo, 32'h22);

    // mthi while busy is ignored; divu 100 / 7
    applyStimulus(2'b10, 32'd100, 32'd7);
    @(negedge clk);
    mthi = 1'b1;
    wd   = 32'hAB;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthi_busy_hi", hi, 32'h11);
    waitIdle(cycles);
    checkOutput("divu_cycles", 32'(cycles + 2), 32'd32);
    checkOutput("divu_lo", lo, 32'd14);
    checkOutput("divu_hi", hi, 32'd2);

    // Signed overflow
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(cycles);
    checkOutput("ovf_lo", lo, 32'h8000_0000);
    checkOutput("ovf_hi", hi, 32'h0);

    // start while busy must not disturb the running multu 7 * 6
    applyStimulus(2'b00, 32'd7, 32'd6);
    @(negedge clk);
    start = 1'b1;
    md_op = 2'b10;
    a     = 32'd1000;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    waitIdle(cycles);
    checkOutput("busy_start_cycles", 32'(cycles + 2), 32'd5);
    checkOutput("busy_start_hi", hi, 32'h0);
    checkOutput("busy_start_lo", lo, 32'd42);
    repeat (3) @(negedge clk);
    checkOutput("busy_start_idle", {31'b0, busy}, 32'h0);

    // Reset during cycle 10 of a divide
    applyStimulus(2'b11, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'b0, busy}, 32'h0);
    checkOutput("midreset_hi", hi, 32'h0);
    checkOutput("midreset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifdef HILO_MULDIV_FLUSH_EN
    mthi = 1'b1;
    mtlo = 1'b1;
    wd   = 32'h77;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    checkOutput("both_mt_hi", hi, 32'h77);
    checkOutput("both_mt_lo", lo, 32'h77);

    // Flush in cycle 3 of a mult
    applyStimulus(2'b01, 32'd5, 32'd5);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'b0, busy}, 32'h0);
    repeat (6) @(negedge clk);
    checkOutput("flush_hi", hi, 32'h77);
    checkOutput("flush_lo", lo, 32'h77);

    // Flush together with start launches nothing
    flush = 1'b1;
    applyStimulus(2'b00, 32'd3, 32'd3);
    flush = 1'b0;
    checkOutput("flush_start_busy", {31'b0, busy}, 32'h0);
    repeat (6) @(negedge clk);
    checkOutput("flush_start_lo", lo, 32'h77);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
    $finish;
  end

endmodule
